keypad_debounce_encoder: RTL

- Upstream input stage for the number-guessing game. Conditions the eight raw keypad switches into a clean one-hot `keypad` bus.
- Includes two-flop synchronisation, per-key debounce and single-key arbitration.
- The one-hot bus feeds the match checker. A 1–8 key code and event pulses feed the game controller and the piezo/LCD logic.
- Only one debounced key is ever presented. Chords (several keys at once) are rejected.

---
 rtl/keypad_debounce_encoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/keypad_debounce_encoder.sv
// Keypad input conditioning: synchronises eight raw switches, debounces each key,
// and arbitrates down to a single accepted key with press/release/chord pulses.
module keypad_debounce_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] key_raw,
  output logic [7:0] keypad,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       multi_key,
  output logic [7:0] stable_keys
);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    WAIT_CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchroniser followed by one retiming stage, so a press sampled at
  // edge 0 reaches the debouncers' compare point after edge 2.
  logic [7:0] sync_meta;
  logic [7:0] sync_q;
  logic [7:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
      sync      <= '0;
    end else begin
      // NOTE: non-blocking assignments make this a shift chain; blocking ones
      // would collapse all three stages into a single flop.
      sync_meta <= key_raw;
      sync_q    <= sync_meta;
      sync      <= sync_q;
    end
  end

  logic [CNT_W-1:0] cnt [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_keys <= '0;
      // NOTE: these counters are an array but still take the async reset, since
      // a reset in the middle of a debounce window must discard its progress.
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync[i] == stable_keys[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_keys[i] <= sync[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic [3:0] stable_code;
  logic       one_key;
  logic       chord;

  always_comb begin
    // NOTE: default first so every path assigns stable_code and no latch forms.
    stable_code = '0;
    for (int i = 0; i < 8; i++) begin
      if (stable_keys[i]) stable_code = 4'(i + 1);
    end
  end

  assign one_key = (stable_keys != 8'd0) && ((stable_keys & (stable_keys - 8'd1)) == 8'd0);
  assign chord   = (stable_keys != 8'd0) && !one_key;

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      keypad      <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        keypad   <= '0;
        key_code <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (one_key) begin
              keypad    <= stable_keys;
              key_code  <= stable_code;
              key_valid <= 1'b1;
              state     <= HELD;
            end else if (chord) begin
              multi_key <= 1'b1;
              state     <= WAIT_CLEAR;
            end
          end
          HELD: begin
            // keypad still holds the accepted bit; other keys are ignored until it drops
            if ((stable_keys & keypad) == 8'd0) begin
              keypad      <= '0;
              key_code    <= '0;
              key_release <= 1'b1;
              state       <= (stable_keys == 8'd0) ? IDLE : WAIT_CLEAR;
            end
          end
          WAIT_CLEAR: begin
            if (stable_keys == 8'd0) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
